// File: rtl/regfile_mp_sb.sv
// Dual-write, dual-read register file with write-to-read bypass and a
// per-register busy scoreboard for the pipeline hazard unit.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] set_addr,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] ra);
        if (is_zero(ra))            return '0;
        else if (we1 && wa1 == ra)  return wd1;
        else if (we0 && wa0 == ra)  return wd0;
        else                        return regs_q[ra];
    endfunction

    // A result landing this cycle releases the stall immediately, matching the bypass.
    function automatic logic busy_fn(input logic [ADDR_W-1:0] ra);
        return busy_q[ra] && !(we0 && wa0 == ra) && !(we1 && wa1 == ra);
    endfunction

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!is_zero(ADDR_W'(i))) begin
                // Port 1 is applied last so it wins a same-address conflict.
                if (we0 && wa0 == ADDR_W'(i)) regs_d[i] = wd0;
                if (we1 && wa1 == ADDR_W'(i)) regs_d[i] = wd1;
                if (set_busy && set_addr == ADDR_W'(i))
                    busy_d[i] = 1'b1;
                else if ((we0 && wa0 == ADDR_W'(i)) || (we1 && wa1 == ADDR_W'(i)))
                    busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign rd1   = rd_fn(ra1);
    assign rd2   = rd_fn(ra2);
    assign busy1 = busy_fn(ra1);
    assign busy2 = busy_fn(ra2);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb; a second instance with ZERO_REG=0
// shares all inputs to show register 0 behaving as an ordinary register.
module tb_regfile_mp_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, set_busy;
    logic [4:0]  wa0, wa1, ra1, ra2, set_addr;
    logic [31:0] wd0, wd1;
    logic [31:0] rd1, rd2, nz_rd1, nz_rd2;
    logic        busy1, busy2, nz_busy1, nz_busy2;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .set_busy(set_busy), .set_addr(set_addr),
        .busy1(busy1), .busy2(busy2)
    );

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(nz_rd1), .rd2(nz_rd2),
        .set_busy(set_busy), .set_addr(set_addr),
        .busy1(nz_busy1), .busy2(nz_busy2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and checks happen mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; set_busy = 1'b0;
    endtask

    initial begin
        reset = 1'b1; idle();
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        ra1 = '0; ra2 = '0; set_addr = '0;
        step();
        reset = 1'b0;

        // 1. reset state on every address
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a); #1;
            chk("rst_rd1", rd1, 32'h0);
            chk("rst_rd2", rd2, 32'h0);
            chk("rst_busy", {30'h0, busy1, busy2}, 32'h0);
        end

        // 2. write then read, and same-cycle bypass
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        step(); idle();
        ra1 = 5'd5; #1;
        chk("wr_rd1", rd1, 32'hDEADBEEF);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1234; ra2 = 5'd7; #1;
        chk("byp_rd2", rd2, 32'h1234);
        step(); idle(); #1;
        chk("byp_store", rd2, 32'h1234);

        // 3. dual-write conflict and distinct addresses
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2; ra1 = 5'd9; #1;
        chk("conf_byp", rd1, 32'h2);
        step(); idle(); #1;
        chk("conf_store", rd1, 32'h2);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44;
        step(); idle();
        ra1 = 5'd3; ra2 = 5'd4; #1;
        chk("dist_rd1", rd1, 32'h33);
        chk("dist_rd2", rd2, 32'h44);

        // 4. zero register
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        set_busy = 1'b1; set_addr = 5'd0; ra1 = 5'd0; #1;
        chk("z_rd_byp", rd1, 32'h0);
        chk("z_busy_byp", {31'h0, busy1}, 32'h0);
        chk("nz_rd_byp", nz_rd1, 32'hFFFF_FFFF);
        step(); idle(); #1;
        chk("z_rd", rd1, 32'h0);
        chk("z_busy", {31'h0, busy1}, 32'h0);
        chk("nz_rd", nz_rd1, 32'hFFFF_FFFF);
        chk("nz_busy", {31'h0, nz_busy1}, 32'h1);

        // 5. scoreboard
        set_busy = 1'b1; set_addr = 5'd10; ra1 = 5'd10; #1;
        chk("sb_set_same", {31'h0, busy1}, 32'h0);
        step(); idle(); #1;
        chk("sb_set_next", {31'h0, busy1}, 32'h1);
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hAA; #1;
        chk("sb_rel_same", {31'h0, busy1}, 32'h0);
        chk("sb_rel_rd", rd1, 32'hAA);
        step(); idle(); #1;
        chk("sb_rel_next", {31'h0, busy1}, 32'h0);
        set_busy = 1'b1; set_addr = 5'd10;
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hBB; #1;
        chk("sb_both_same", {31'h0, busy1}, 32'h0);
        step(); idle(); #1;
        chk("sb_both_next", {31'h0, busy1}, 32'h1);
        chk("sb_both_rd", rd1, 32'hBB);

        // 6. reset mid-operation
        set_busy = 1'b1; set_addr = 5'd12;
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hA5;
        step(); idle();
        ra1 = 5'd12; ra2 = 5'd10; #1;
        chk("pre_rst_rd", rd1, 32'hA5);
        chk("pre_rst_busy", {30'h0, busy1, busy2}, 32'h3);
        reset = 1'b1; we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h77; #1;
        chk("in_rst_byp", rd1, 32'h77);
        step(); reset = 1'b0; idle(); #1;
        chk("post_rst_rd1", rd1, 32'h0);
        chk("post_rst_rd2", rd2, 32'h0);
        chk("post_rst_busy", {30'h0, busy1, busy2}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the pipelined MIPS datapath. Successor to the single-write 32x32 register file.
- Two read ports and two write ports: one for the ALU/writeback path, one for the load/multi-cycle path.
- Write-to-read bypass, so a register written this cycle is readable in the same cycle.
- Per-register busy scoreboard that the hazard unit uses to stall on pending producers.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width. Depth = 2**ADDR_W registers.
- ZERO_REG, 1. When 1, register 0 reads 0, ignores writes and is never busy. When 0, register 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we0  in  1  write enable, port 0.
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- ra1  in  ADDR_W  read address A.
- ra2  in  ADDR_W  read address B.
- rd1  out  DATA_W  read data A (combinational).
- rd2  out  DATA_W  read data B (combinational).
- set_busy  in  1  mark register set_addr as pending a result.
- set_addr  in  ADDR_W  destination of the newly issued producer.
- busy1  out  1  register ra1 has a pending producer.
- busy2  out  1  register ra2 has a pending producer.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
  - At a rising edge with reset=1: all registers become 0 and all busy bits become 0.
  - reset overrides we0, we1 and set_busy in that cycle.
- Post-reset outputs:
  - rd1 = rd2 = 0.
  - busy1 = busy2 = 0, until the first write or set_busy.
- Writes:
  - At a rising edge, reg[waN] <= wdN when weN=1.
  - Latency: 0 cycles through the bypass, 1 cycle through storage.
- Same-address write conflict: we0 and we1 both set with wa0 == wa1 -> port 1's data is stored; port 0's write is discarded.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are ignored.
  - rd = 0 whenever ra = 0, including under bypass.
  - set_busy with set_addr = 0 has no effect.
- Read bypass, evaluated per read port, highest priority first:
  1. ZERO_REG zero rule.
  2. we1 && wa1 == ra -> wd1.
  3. we0 && wa0 == ra -> wd0.
  4. Stored reg[ra].
- Reads are purely combinational from the address, storage and write inputs. They are not gated by reset; during reset, rd reflects the bypass and stored values until the clock edge.
- Scoreboard: one busy bit per register. Next state at each rising edge, for address a:
  - set when set_busy && set_addr == a;
  - else cleared when (we0 && wa0 == a) or (we1 && wa1 == a);
  - else held.
  - A simultaneous set and clear on the same address leaves the bit set: the new producer wins.
- Busy outputs are combinational:
  - busyN = busy[raN] && !(we0 && wa0 == raN) && !(we1 && wa1 == raN).
  - A result arriving this cycle releases the stall in the same cycle, consistent with the bypass.
  - A set_busy issued this cycle is not visible on busyN until the next cycle.
- Reset mid-operation: pending busy bits are lost and the data is zeroed. The hazard unit must flush the pipeline together with reset.
- No X propagation: all storage is initialised by reset. Before the first reset, content is undefined.

Test Plan:
1. Reset: assert reset 1 cycle, then read every address on both ports -> all 0; busy1 = busy2 = 0.
2. Write/read: we0, wa0=5, wd0=32'hDEADBEEF for 1 cycle, then ra1=5 -> rd1=32'hDEADBEEF.
   - Same-cycle bypass: we0, wa0=7, wd0=32'h1234, ra2=7 -> rd2=32'h1234 in that cycle; storage holds it next cycle.
3. Dual-write conflict: wa0 = wa1 = 9, wd0=32'h1, wd1=32'h2 -> same cycle and after, ra1=9 gives 32'h2.
   - Distinct addresses 3 and 4 in the same cycle -> both stored.
4. Zero register (ZERO_REG=1): we1, wa1=0, wd1=32'hFFFF_FFFF; set_busy, set_addr=0 -> ra1=0 gives rd1=0 and busy1=0, same cycle and next.
   - Rerun with ZERO_REG=0 -> rd1=32'hFFFF_FFFF next cycle.
5. Scoreboard:
   - set_busy on 10 -> busy1 (ra1=10) is 1 from the next cycle.
   - we0 to 10 -> busy1=0 in the write cycle.
   - Set and write on 10 in the same cycle -> busy1 is 1 afterwards.
6. Reset mid-operation: busy on 12 and reg 12 = 32'hA5 -> assert reset together with we1 to 12 -> after the edge, reg 12 = 0 and busy = 0.
